// File: rtl/find_stars_pkg.sv
// Shared sizes, frame geometry and scanner state encoding for the star-finding pipeline.
package find_stars_pkg;

  localparam int unsigned X_SZ     = 8;
  localparam int unsigned Y_SZ     = 7;
  localparam int unsigned COL_SZ   = 3;
  localparam int unsigned ADDR_SZ  = 15;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned LAST_PIX = SCREEN_W * SCREEN_H - 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scan_state_e;

endpackage

// File: rtl/star_scanner_raster_addr.sv
// raster_addr: combinational frame-buffer address y*160 + x, built from shifts and adds.
module raster_addr #(
  parameter int unsigned X_SZ    = find_stars_pkg::X_SZ,
  parameter int unsigned Y_SZ    = find_stars_pkg::Y_SZ,
  parameter int unsigned ADDR_SZ = find_stars_pkg::ADDR_SZ
) (
  input  logic [X_SZ-1:0]    x_i,
  input  logic [Y_SZ-1:0]    y_i,
  output logic [ADDR_SZ-1:0] addr_o
);

  logic [ADDR_SZ-1:0] x_ext;
  logic [ADDR_SZ-1:0] y_ext;

  // 160*y = 128*y + 32*y; the maximum (19199) fits in 15 bits.
  always_comb begin
    x_ext  = ADDR_SZ'(x_i);
    y_ext  = ADDR_SZ'(y_i);
    addr_o = (y_ext << 7) + (y_ext << 5) + x_ext;
  end

endmodule

// File: rtl/star_scanner.sv
// star_scanner: raster-scans the frame buffer for the first star-coloured pixel.
// Optional STAR_SCAN_RESUME_EN: each scan resumes just after the previous hit.
module star_scanner #(
  parameter int unsigned       X_SZ     = find_stars_pkg::X_SZ,
  parameter int unsigned       Y_SZ     = find_stars_pkg::Y_SZ,
  parameter int unsigned       COL_SZ   = find_stars_pkg::COL_SZ,
  parameter int unsigned       ADDR_SZ  = find_stars_pkg::ADDR_SZ,
  parameter logic [COL_SZ-1:0] STAR_COL = 3'b111
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  output logic [ADDR_SZ-1:0] mem_addr,
  input  logic [COL_SZ-1:0]  mem_data,
  output logic [X_SZ-1:0]    x_out,
  output logic [Y_SZ-1:0]    y_out,
  output logic               star_found,
  output logic               scan_done,
  output logic               busy
);

  import find_stars_pkg::*;

  localparam logic [X_SZ-1:0] X_LAST = X_SZ'(SCREEN_W - 1);
  localparam logic [Y_SZ-1:0] Y_LAST = Y_SZ'(SCREEN_H - 1);

  scan_state_e state_q, state_d;

  logic [X_SZ-1:0]    x_q, x_d, x_inc, x_dly_q, x_dly_d, x_out_q, x_out_d, start_x;
  logic [Y_SZ-1:0]    y_q, y_d, y_inc, y_dly_q, y_dly_d, y_out_q, y_out_d, start_y;
  logic               vld_q, vld_d;
  logic               found_q, found_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic               hit;
  logic               at_last;

  raster_addr #(
    .X_SZ    (X_SZ),
    .Y_SZ    (Y_SZ),
    .ADDR_SZ (ADDR_SZ)
  ) u_raster_addr (
    .x_i    (x_d),
    .y_i    (y_d),
    .addr_o (addr_d)
  );

  always_comb begin
    if (x_q == X_LAST) begin
      x_inc = '0;
      y_inc = y_q + 1'b1;
    end else begin
      x_inc = x_q + 1'b1;
      y_inc = y_q;
    end
  end

  // Delayed coordinates/valid track the pixel whose read data is on mem_data now.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x_dly_d = x_dly_q;
    y_dly_d = y_dly_q;
    vld_d   = vld_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    found_d = 1'b0;
    done_d  = 1'b0;
    hit     = vld_q && (mem_data == STAR_COL);
    at_last = (x_q == X_LAST) && (y_q == Y_LAST);

    unique case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (start) begin
          state_d = SCAN;
          x_d     = start_x;
          y_d     = start_y;
        end
      end
      SCAN: begin
        if (hit) begin
          // The read issued this cycle is speculative and simply dropped.
          state_d = IDLE;
          vld_d   = 1'b0;
          found_d = 1'b1;
          x_out_d = x_dly_q;
          y_out_d = y_dly_q;
        end else begin
          x_dly_d = x_q;
          y_dly_d = y_q;
          vld_d   = 1'b1;
          if (at_last) begin
            state_d = DRAIN;
          end else begin
            x_d = x_inc;
            y_d = y_inc;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        if (hit) begin
          found_d = 1'b1;
          x_out_d = x_dly_q;
          y_out_d = y_dly_q;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x_dly_q <= '0;
      y_dly_q <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x_dly_q <= x_dly_d;
      y_dly_q <= y_dly_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      found_q <= found_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef STAR_SCAN_RESUME_EN
  logic [X_SZ-1:0] res_x_q, res_x_d;
  logic [Y_SZ-1:0] res_y_q, res_y_d;

  // Resume point is the pixel after the hit; a hit on the last pixel or a miss restarts at 0.
  always_comb begin
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    if (found_d) begin
      if (x_dly_q == X_LAST) begin
        res_x_d = '0;
        res_y_d = (y_dly_q == Y_LAST) ? '0 : y_dly_q + 1'b1;
      end else begin
        res_x_d = x_dly_q + 1'b1;
        res_y_d = y_dly_q;
      end
    end else if (done_d) begin
      res_x_d = '0;
      res_y_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_x_q <= '0;
      res_y_q <= '0;
    end else begin
      res_x_q <= res_x_d;
      res_y_q <= res_y_d;
    end
  end

  assign start_x = res_x_q;
  assign start_y = res_y_q;
`else
  assign start_x = '0;
  assign start_y = '0;
`endif

  assign mem_addr   = addr_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign star_found = found_q;
  assign scan_done  = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_star_scanner.sv
// Self-checking bench for star_scanner against a frame-level reference model (first star at or after start index).
module tb_star_scanner;

  localparam int NPIX = 19200;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic        star_found;
  logic        scan_done;
  logic        busy;

  logic [2:0] fb [NPIX];

  int total = 0;
  int bad   = 0;
  int res_s = 0;
  int exp_xo = 0;
  int exp_yo = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= fb[int'(mem_addr)];

  star_scanner dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .x_out      (x_out),
    .y_out      (y_out),
    .star_found (star_found),
    .scan_done  (scan_done),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int first_star(input int s);
    for (int i = s; i < NPIX; i++) if (fb[i] == 3'b111) return i;
    return -1;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < NPIX; i++) fb[i] = 3'b000;
  endtask

  task automatic put(input int x, input int y, input logic [2:0] c);
    fb[y * 160 + x] = c;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_xout"},  x_out, 0);
    chk({tag, "_yout"},  y_out, 0);
    chk({tag, "_found"}, star_found, 0);
    chk({tag, "_done"},  scan_done, 0);
    chk({tag, "_busy"},  busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    res_s  = 0;
    exp_xo = 0;
    exp_yo = 0;
  endtask

  // Ends at the negedge following E0.
  task automatic launch(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic finish_scan(input string tag);
    int s, p, n, exp_n, ea, addr_bad, busy_bad;
    s = res_s;
    p = first_star(s);
    n = 0;
    addr_bad = 0;
    busy_bad = 0;
    chk({tag, "_busy_e0"}, busy, 1);
    while (!star_found && !scan_done && n < 20000) begin
      ea = (s + n > NPIX - 1) ? NPIX - 1 : s + n;
      if (mem_addr !== 15'(ea)) addr_bad++;
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      n++;
    end
    exp_n = (p >= 0) ? p - s + 2 : NPIX + 1 - s;
    chk({tag, "_latency"}, n, exp_n);
    chk({tag, "_found"}, star_found, (p >= 0) ? 1 : 0);
    chk({tag, "_done"},  scan_done, (p < 0) ? 1 : 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_addr_seq_errs"}, addr_bad, 0);
    chk({tag, "_busy_seq_errs"}, busy_bad, 0);
    if (p >= 0) begin
      exp_xo = p % 160;
      exp_yo = p / 160;
    end
    chk({tag, "_xout"}, x_out, exp_xo);
    chk({tag, "_yout"}, y_out, exp_yo);
`ifdef STAR_SCAN_RESUME_EN
    res_s = (p >= 0 && p < NPIX - 1) ? p + 1 : 0;
`else
    res_s = 0;
`endif
    @(negedge clk);
    chk({tag, "_pulse_len"}, {star_found, scan_done}, 0);
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    clear_frame();
    do_reset("reset");

    // Blank frame: full scan ends in scan_done.
    launch(1'b0);
    finish_scan("blank");

    // Reset mid-scan aborts with all outputs cleared.
    launch(1'b0);
    repeat (5000) @(negedge clk);
    chk("mid_addr", mem_addr, 5000);
    chk("mid_busy", busy, 1);
    do_reset("rst_mid");

    clear_frame();
    put(0, 0, 3'b111);
    launch(1'b0);
    finish_scan("p00");

    // start held high re-triggers directly after the return to IDLE.
    put(5, 0, 3'b111);
    put(0, 2, 3'b111);
    launch(1'b1);
    finish_scan("retrig1");
    start = 1'b0;
    finish_scan("retrig2");

    do_reset("rst_a");
    clear_frame();
    put(159, 0, 3'b111);
    put(0, 1, 3'b111);
    launch(1'b0);
    finish_scan("rowwrap");

    do_reset("rst_b");
    clear_frame();
    put(159, 119, 3'b111);
    launch(1'b0);
    finish_scan("lastpix");

    clear_frame();
    put(10, 3, 3'b111);
    put(20, 3, 3'b111);
    put(15, 3, 3'b110);
    for (int k = 0; k < 4; k++) begin
      launch(1'b0);
      finish_scan($sformatf("pair%0d", k));
    end

    // Random noise frames (no star colour) with a few stars near the top.
    for (int r = 0; r < 3; r++) begin
      do_reset($sformatf("rst_r%0d", r));
      for (int i = 0; i < NPIX; i++) fb[i] = 3'($urandom_range(0, 6));
      for (int j = 0; j < 2; j++) fb[$urandom_range(0, 2999)] = 3'b111;
      launch(1'b0);
      finish_scan($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
